// File: rtl/cap_volt_monitor_mc.sv
// cap_volt_monitor_mc: multi-channel capacitor voltage monitor.
// Shared round-robin scale/compare pipeline, debounced flags with hysteresis.

module cap_volt_monitor_mc #(
  parameter int N_CH = 3,
  parameter int ADC_W = 14,
  parameter logic [N_CH*32-1:0] GAIN_Q16 =
    {32'd96006, 32'd40004, 32'd65542},
  parameter logic [N_CH*32-1:0] OFFSET_MV =
    {32'd12000, 32'd5000, 32'd0},
  parameter logic [N_CH*16-1:0] STEP_MV =
    {16'd240, 16'd100, 16'd100},
  parameter int DEB_N = 3,
  parameter int HYST_MV = 500
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic [N_CH*ADC_W-1:0] adc_data,
  input  logic [N_CH-1:0]       adc_valid,
  input  logic [N_CH*8-1:0]     set_code,
  output logic [N_CH*32-1:0]    value_mv,
  output logic                  value_valid,
  output logic [2:0]            value_ch,
  output logic [N_CH-1:0]       cap_flag,
  output logic [N_CH-1:0]       overrun
);

  localparam logic [3:0] DEB = 4'(DEB_N);
  localparam logic signed [31:0] HYST = 32'(HYST_MV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SCALE,
    S_CMP
  } state_t;

  state_t state_q, state_d;

  logic [N_CH-1:0][ADC_W-1:0] hold_q, hold_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] overrun_q, overrun_d;
  logic [2:0] rr_q, rr_d;
  logic [2:0] ch_q, ch_d;
  logic [ADC_W-1:0] work_q, work_d;
  logic [47:0] prod_q, prod_d;
  logic signed [31:0] mv_q, mv_d;
  logic [31:0] thr_q, thr_d;
  logic [N_CH-1:0][3:0] cnt_q, cnt_d;
  logic [N_CH-1:0][31:0] vmv_q, vmv_d;
  logic vv_q, vv_d;
  logic [2:0] vch_q, vch_d;
  logic [N_CH-1:0] flag_q, flag_d;

  logic lo_vld, hi_vld, pick_vld, take;
  logic [2:0] lo_ch, hi_ch, pick_ch;
  logic [ADC_W-1:0] pick_code;
  logic [31:0] gain_sel, off_sel;
  logic [15:0] step_sel;
  logic [7:0] set_sel;
  logic [3:0] cnt_sel, cnt_new;
  logic signed [31:0] clr_lvl;
  logic unused_prod;

  // low product bits fall below the Q16 point
  assign unused_prod = ^prod_q[15:0];

  assign value_mv = vmv_q;
  assign value_valid = vv_q;
  assign value_ch = vch_q;
  assign cap_flag = flag_q;
  assign overrun = overrun_q;

  // round-robin arbiter: lowest pending at/after rr_q, else lowest
  always_comb begin
    lo_vld = 1'b0;
    lo_ch = '0;
    hi_vld = 1'b0;
    hi_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lo_vld = 1'b1;
        lo_ch = 3'(i);
        if (3'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_ch = 3'(i);
        end
      end
    end
    pick_vld = lo_vld;
    pick_ch = hi_vld ? hi_ch : lo_ch;
    take = enable && (state_q == S_IDLE) && pick_vld;
  end

  // per-channel constant and state muxes
  always_comb begin
    pick_code = '0;
    gain_sel = '0;
    off_sel = '0;
    step_sel = '0;
    set_sel = '0;
    cnt_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_ch == 3'(i)) begin
        pick_code = hold_q[i];
      end
      if (ch_q == 3'(i)) begin
        gain_sel = GAIN_Q16[i*32 +: 32];
        off_sel = OFFSET_MV[i*32 +: 32];
        step_sel = STEP_MV[i*16 +: 16];
        set_sel = set_code[i*8 +: 8];
        cnt_sel = cnt_q[i];
      end
    end
  end

  // debounce counter update with hysteresis band
  always_comb begin
    clr_lvl = $signed(thr_q) - HYST;
    cnt_new = cnt_sel;
    if (mv_q >= $signed(thr_q)) begin
      if (cnt_sel < DEB) begin
        cnt_new = cnt_sel + 4'd1;
      end
    end else if (mv_q < clr_lvl) begin
      cnt_new = '0;
    end
  end

  // sample capture, pending and overrun tracking
  always_comb begin
    hold_d = hold_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!enable) begin
      pending_d = '0;
      overrun_d = '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (take && (pick_ch == 3'(i))) begin
          pending_d[i] = 1'b0;
        end
        if (adc_valid[i]) begin
          hold_d[i] = adc_data[i*ADC_W +: ADC_W];
          if (pending_q[i] && !(take && (pick_ch == 3'(i)))) begin
            overrun_d[i] = 1'b1;
          end
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  // conversion FSM and datapath
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    ch_d = ch_q;
    work_d = work_q;
    prod_d = prod_q;
    mv_d = mv_q;
    thr_d = thr_q;
    cnt_d = cnt_q;
    vmv_d = vmv_q;
    vv_d = 1'b0;
    vch_d = vch_q;
    flag_d = flag_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d = '0;
      flag_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            ch_d = pick_ch;
            work_d = pick_code;
            rr_d = (pick_ch == 3'(N_CH - 1)) ? 3'd0 : pick_ch + 3'd1;
            state_d = S_MUL;
          end
        end
        S_MUL: begin
          prod_d = 48'(work_q) * 48'(gain_sel);
          state_d = S_SCALE;
        end
        S_SCALE: begin
          mv_d = $signed(prod_q[47:16]) - $signed(off_sel);
          thr_d = 32'(set_sel) * 32'(step_sel);
          state_d = S_CMP;
        end
        S_CMP: begin
          for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 3'(i)) begin
              cnt_d[i] = cnt_new;
              vmv_d[i] = mv_q;
              flag_d[i] = (cnt_new == DEB);
            end
          end
          vv_d = 1'b1;
          vch_d = ch_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rr_q <= '0;
      ch_q <= '0;
      work_q <= '0;
      prod_q <= '0;
      mv_q <= '0;
      thr_q <= '0;
      cnt_q <= '0;
      vmv_q <= '0;
      vv_q <= 1'b0;
      vch_q <= '0;
      flag_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_q <= rr_d;
      ch_q <= ch_d;
      work_q <= work_d;
      prod_q <= prod_d;
      mv_q <= mv_d;
      thr_q <= thr_d;
      cnt_q <= cnt_d;
      vmv_q <= vmv_d;
      vv_q <= vv_d;
      vch_q <= vch_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: tb/tb_cap_volt_monitor_mc.sv
// tb_cap_volt_monitor_mc: vector table, corner sequences and random
// transactions against a transaction-level reference model.
`timescale 1ns/1ps

module tb_cap_volt_monitor_mc;

  localparam int N = 3;

  logic sys_clk;
  logic sys_rst_n;
  logic enable;
  logic [N*14-1:0] adc_data;
  logic [N-1:0] adc_valid;
  logic [N*8-1:0] set_code;
  logic [N*32-1:0] value_mv;
  logic value_valid;
  logic [2:0] value_ch;
  logic [N-1:0] cap_flag;
  logic [N-1:0] overrun;

  int n_tests = 0;
  int n_fail = 0;

  int gain_m[3] = '{65542, 40004, 96006};
  int off_m[3] = '{0, 5000, 12000};
  int step_m[3] = '{100, 100, 240};
  int cnt_m[3];
  int rr_m;

  typedef struct {
    int ch;
    int code;
    int set;
    int exp_mv;
    int exp_flag;
  } vec_t;

  vec_t tbl[14];

  cap_volt_monitor_mc #(
    .N_CH(3),
    .ADC_W(14),
    .GAIN_Q16({32'd96006, 32'd40004, 32'd65542}),
    .OFFSET_MV({32'd12000, 32'd5000, 32'd0}),
    .STEP_MV({16'd240, 16'd100, 16'd100}),
    .DEB_N(3),
    .HYST_MV(500)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable(enable),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .set_code(set_code),
    .value_mv(value_mv),
    .value_valid(value_valid),
    .value_ch(value_ch),
    .cap_flag(cap_flag),
    .overrun(overrun)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_mv(int ch, int code);
    longint p;
    p = longint'(code) * longint'(gain_m[ch]);
    return int'(p / 64'sd65536) - off_m[ch];
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(int ch, int code, int s,
                            output int mv, output int flag);
    int thr;
    mv = model_mv(ch, code);
    thr = s * step_m[ch];
    if (mv >= thr) cnt_m[ch] = (cnt_m[ch] < 3) ? cnt_m[ch] + 1 : 3;
    else if (mv < thr - 500) cnt_m[ch] = 0;
    flag = (cnt_m[ch] == 3) ? 1 : 0;
    rr_m = (ch + 1) % 3;
  endtask

  task automatic strobe(logic [2:0] m, int c0, int c1, int c2);
    adc_data = {14'(c2), 14'(c1), 14'(c0)};
    adc_valid = m;
    @(negedge sys_clk);
    adc_valid = '0;
  endtask

  task automatic strobe_one(int ch, int code);
    int c[3];
    c = '{0, 0, 0};
    c[ch] = code;
    strobe(3'(1 << ch), c[0], c[1], c[2]);
  endtask

  task automatic wait_vv(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge sys_clk);
      if (value_valid) begin
        ok = 1'b1;
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_conv(string tag, int ch, int emv, int eflag,
                             int elat);
    int lat;
    bit ok;
    wait_vv(lat, ok);
    chk({tag, "_seen"}, ok, 1);
    if (ok) begin
      chk({tag, "_ch"}, value_ch, ch);
      chk({tag, "_mv"}, $signed(value_mv[ch*32 +: 32]), emv);
      chk({tag, "_flag"}, cap_flag[ch], eflag);
      if (elat >= 0) chk({tag, "_lat"}, lat, elat);
    end
  endtask

  task automatic expect_model(string tag, int ch, int code, int s,
                              int elat);
    int mv;
    int fl;
    model_step(ch, code, s, mv, fl);
    expect_conv(tag, ch, mv, fl, elat);
  endtask

  task automatic no_vv(int cycles, string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge sys_clk);
      if (value_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic do_reset(string tag);
    sys_rst_n = 1'b0;
    adc_valid = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk({tag, "_mv"}, (value_mv == '0), 1);
    chk({tag, "_vv"}, value_valid, 0);
    chk({tag, "_vch"}, value_ch, 0);
    chk({tag, "_flag"}, cap_flag, 0);
    chk({tag, "_ovr"}, overrun, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    cnt_m = '{0, 0, 0};
    rr_m = 0;
  endtask

  int sv[3];
  int cd[3];
  int ord[$];
  logic [2:0] msk;
  int mv_t;
  int fl_t;
  int r0;

  initial begin
    tbl[0] = '{2, 16383, 0, 12000, 0};
    tbl[1] = '{2, 8192, 0, 0, 0};
    tbl[2] = '{2, 0, 0, -12000, 0};
    tbl[3] = '{0, 16383, 0, 16384, 0};
    tbl[4] = '{1, 16383, 0, 5000, 0};
    tbl[5] = '{1, 0, 0, -5000, 0};
    tbl[6] = '{2, 16383, 50, 12000, 0};
    tbl[7] = '{2, 16383, 50, 12000, 0};
    tbl[8] = '{2, 16383, 50, 12000, 1};
    tbl[9] = '{2, 16110, 50, 11600, 1};
    tbl[10] = '{2, 15974, 50, 11400, 0};
    tbl[11] = '{2, 16383, 50, 12000, 0};
    tbl[12] = '{2, 16383, 50, 12000, 0};
    tbl[13] = '{2, 16383, 50, 12000, 1};

    sys_rst_n = 1'b0;
    enable = 1'b1;
    adc_valid = '0;
    adc_data = '0;
    set_code = '0;
    do_reset("rst0");

    // all three channels in one clock
    strobe(3'b111, 16383, 16383, 0);
    expect_model("t4_0", 0, 16383, 0, 4);
    expect_model("t4_1", 1, 16383, 0, 4);
    expect_model("t4_2", 2, 0, 0, 4);

    // reset in the middle of a conversion
    strobe_one(2, 16383);
    @(negedge sys_clk);
    @(negedge sys_clk);
    do_reset("rst_mid");
    no_vv(8, "rst_mid_novv");

    // vector table
    for (int i = 0; i < 14; i++) begin
      set_code[tbl[i].ch*8 +: 8] = 8'(tbl[i].set);
      strobe_one(tbl[i].ch, tbl[i].code);
      model_step(tbl[i].ch, tbl[i].code, tbl[i].set, mv_t, fl_t);
      expect_conv($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].exp_mv,
                  tbl[i].exp_flag, 4);
    end

    // back-to-back ch1 strobes while busy
    set_code = '0;
    strobe_one(0, 100);
    strobe_one(1, 16383);
    strobe_one(1, 0);
    expect_model("t5_0", 0, 100, 0, -1);
    expect_model("t5_1", 1, 0, 0, -1);
    no_vv(10, "t5_extra");
    chk("t5_ovr", overrun, 3'b010);

    // enable dropped mid-MUL
    strobe_one(2, 16383);
    @(negedge sys_clk);
    enable = 1'b0;
    strobe_one(0, 16383);
    @(negedge sys_clk);
    enable = 1'b1;
    cnt_m = '{0, 0, 0};
    no_vv(12, "t6_novv");
    chk("t6_flag", cap_flag, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_hold", $signed(value_mv[64 +: 32]), 12000);
    strobe_one(2, 16383);
    expect_model("t6_a", 2, 16383, 0, 4);
    strobe_one(2, 8192);
    expect_model("t6_b", 2, 8192, 0, 4);
    strobe_one(2, 0);
    expect_model("t6_c", 2, 0, 0, 4);

    // set_code change after SCALE must not affect this conversion
    strobe_one(2, 16383);
    expect_model("sc_a", 2, 16383, 0, 4);
    strobe_one(2, 16383);
    expect_model("sc_b", 2, 16383, 0, 4);
    strobe_one(2, 16383);
    repeat (3) @(negedge sys_clk);
    set_code[16 +: 8] = 8'd255;
    expect_model("sc_c", 2, 16383, 0, -1);
    set_code = '0;

    do_reset("rst1");

    // randomized transactions
    for (int it = 0; it < 150; it++) begin
      for (int k = 0; k < 3; k++) begin
        sv[k] = int'($urandom_range(0, (k == 0) ? 170 : 55));
        set_code[k*8 +: 8] = 8'(sv[k]);
        if ($urandom_range(0, 1) == 1)
          cd[k] = 16383 - int'($urandom_range(0, 600));
        else
          cd[k] = int'($urandom_range(0, 16383));
      end
      msk = 3'($urandom_range(1, 7));
      ord.delete();
      r0 = rr_m;
      for (int k = 0; k < 3; k++) begin
        if (msk[(r0 + k) % 3]) ord.push_back((r0 + k) % 3);
      end
      strobe(msk, cd[0], cd[1], cd[2]);
      foreach (ord[j]) begin
        expect_model($sformatf("rnd%0d_%0d", it, j), ord[j],
                     cd[ord[j]], sv[ord[j]], (j == 0) ? 4 : -1);
      end
    end
    chk("rnd_ovr", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
